// File: rtl/c3lib_ckmux_pkg.sv
// -----------------------------------------------------------------------------
// c3lib_ckmux_pkg
//   Shared types and constants for the 4:1 clock-mux select sequencer.
//   - ckmux_seq_state_e : sequencer state encoding (2 bits)
//   - CKMUX_SEL_W       : width of the {s1,s0} mux select
//   - CKMUX_SEL_RST     : mux select driven out of reset
// -----------------------------------------------------------------------------
package c3lib_ckmux_pkg;

    localparam int unsigned CKMUX_SEL_W = 2;

    localparam logic [CKMUX_SEL_W-1:0] CKMUX_SEL_RST = 2'b00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_OFF = 2'd1,
        SWITCH   = 2'd2,
        GATE_ON  = 2'd3
    } ckmux_seq_state_e;

endpackage : c3lib_ckmux_pkg

// File: rtl/c3lib_ckmux4_sel_seq_dncnt.sv
// -----------------------------------------------------------------------------
// c3lib_dncnt_load
//   Loadable down-counter with a zero flag. Used as the wait timer of the
//   clock-mux select sequencer. Load has priority over decrement; the count
//   holds at zero rather than wrapping.
//
//   clk      : reference clock
//   rst      : synchronous reset, active-high (count returns to 0)
//   load     : load load_val on the next edge
//   load_val : value to load
//   dec      : decrement on the next edge (ignored at zero)
//   is_zero  : count is zero
// -----------------------------------------------------------------------------
module c3lib_dncnt_load #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_zero = (cnt_q == '0);

endmodule : c3lib_dncnt_load

// File: rtl/c3lib_ckmux4_sel_seq.sv
// -----------------------------------------------------------------------------
// c3lib_ckmux4_sel_seq
//   Sequences a select change of the 4:1 clock mux inside a gated window so no
//   runt clock reaches downstream logic: gate off, wait GATE_OFF_CYC, change
//   {s1,s0}, wait SETTLE_CYC, gate back on, pulse done.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | gate enabled, waiting for a request
//   GATE_OFF | gate disabled, waiting before touching the selects
//   SWITCH   | selects updated, waiting for the mux output to settle
//   GATE_ON  | gate re-enabled, reporting completion
//
//   Ports
//   clk          : free-running reference clock (independent of muxed clocks)
//   rst          : synchronous reset, active-high
//   req_valid    : select request present (held until accepted)
//   req_sel      : requested {s1,s0}
//   req_ready    : request accepted on an edge where req_valid & req_ready
//   tst_override : scan/test override; freezes the sequencer in IDLE
//   s0, s1       : mux selects (registered)
//   ck_gate_en   : downstream clock-gate enable (registered)
//   busy         : switch sequence in progress
//   done         : one-cycle pulse when a request completes
//
//   All outputs are flops. req_ready is registered from the next state, so it
//   follows tst_override one cycle late and is low during the done cycle; the
//   latter keeps done from pulsing on two consecutive cycles.
// -----------------------------------------------------------------------------
module c3lib_ckmux4_sel_seq
    import c3lib_ckmux_pkg::*;
#(
    parameter int unsigned GATE_OFF_CYC = 4,
    parameter int unsigned SETTLE_CYC   = 8,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [CKMUX_SEL_W-1:0] req_sel,
    output logic                   req_ready,
    input  logic                   tst_override,
    output logic                   s0,
    output logic                   s1,
    output logic                   ck_gate_en,
    output logic                   busy,
    output logic                   done
);

    // Counter terminal count is zero, so load one less than the wait length.
    localparam logic [CNT_W-1:0] GOFF_LOAD   = CNT_W'(GATE_OFF_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    ckmux_seq_state_e        state_q, state_d;
    logic [CKMUX_SEL_W-1:0]  sel_q, sel_d;
    logic [CKMUX_SEL_W-1:0]  tgt_sel_q, tgt_sel_d;
    logic                    gate_en_q, gate_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ready_q, ready_d;

    logic                    cnt_load;
    logic [CNT_W-1:0]        cnt_load_val;
    logic                    cnt_dec;
    logic                    cnt_zero;
    logic                    accept;

    c3lib_dncnt_load #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .is_zero  (cnt_zero)
    );

    assign accept = req_valid & ready_q;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        tgt_sel_d    = tgt_sel_q;
        gate_en_d    = gate_en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                // Gate is held on in IDLE; this also covers the test override.
                gate_en_d = 1'b1;
                busy_d    = 1'b0;
                if (accept) begin
                    tgt_sel_d = req_sel;
                    if (req_sel == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = GATE_OFF;
                        gate_en_d    = 1'b0;
                        busy_d       = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = GOFF_LOAD;
                    end
                end
            end

            GATE_OFF: begin
                if (cnt_zero) begin
                    sel_d        = tgt_sel_q;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETTLE_LOAD;
                    state_d      = SWITCH;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            SWITCH: begin
                if (cnt_zero) begin
                    gate_en_d = 1'b1;
                    state_d   = GATE_ON;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            GATE_ON: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                gate_en_d = 1'b1;
                busy_d    = 1'b0;
            end
        endcase

        ready_d = (state_d == IDLE) & ~tst_override & ~done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= CKMUX_SEL_RST;
            tgt_sel_q <= CKMUX_SEL_RST;
            gate_en_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            tgt_sel_q <= tgt_sel_d;
            gate_en_q <= gate_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign s1         = sel_q[1];
    assign s0         = sel_q[0];
    assign ck_gate_en = gate_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign req_ready  = ready_q;

endmodule : c3lib_ckmux4_sel_seq

// File: tb/tb_c3lib_ckmux4_sel_seq.sv
module tb_c3lib_ckmux4_sel_seq;

    localparam int G  = 4;
    localparam int S  = 8;
    localparam int G2 = 1;
    localparam int S2 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, req_valid, tst_override;
    logic [1:0] req_sel;
    logic       req_ready, s0, s1, ck_gate_en, busy, done;

    logic       rst2, req_valid2, tst_override2;
    logic [1:0] req_sel2;
    logic       req_ready2, s0_2, s1_2, ck_gate_en2, busy2, done2;

    c3lib_ckmux4_sel_seq #(.GATE_OFF_CYC(G), .SETTLE_CYC(S), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
        .req_ready(req_ready), .tst_override(tst_override), .s0(s0), .s1(s1),
        .ck_gate_en(ck_gate_en), .busy(busy), .done(done)
    );

    c3lib_ckmux4_sel_seq #(.GATE_OFF_CYC(G2), .SETTLE_CYC(S2), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst2), .req_valid(req_valid2), .req_sel(req_sel2),
        .req_ready(req_ready2), .tst_override(tst_override2), .s0(s0_2), .s1(s1_2),
        .ck_gate_en(ck_gate_en2), .busy(busy2), .done(done2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time is counted in clock edges; "post-edge e" is what the outputs show
    // after edge e. A switch accepted at edge ta shows, at offset k = e - ta:
    // gate low for k in [0, G+S-1], new select from k = G, busy for
    // k in [0, G+S], done at k = G+S+1. A same-select request shows done at k=0.
    int         e         = 0;
    int         ta        = 0;
    bit         seq       = 0;
    logic [1:0] m_old     = 2'b00;
    logic [1:0] m_new     = 2'b00;
    int         done_edge = -100;
    bit         m_ready   = 1;
    bit         m_acc     = 0;

    function automatic logic [1:0] f_sel(input int ed);
        return (seq && (ed - ta) >= G) ? m_new : m_old;
    endfunction
    function automatic bit f_gate(input int ed);
        return !(seq && (ed - ta) <= G + S - 1);
    endfunction
    function automatic bit f_busy(input int ed);
        return seq && (ed - ta) <= G + S;
    endfunction
    function automatic bit f_done(input int ed);
        return (done_edge == ed) || (seq && (ed - ta) == G + S + 1);
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic [1:0] rs, input logic ov);
        logic [1:0] cur;
        bit acc;
        cur = f_sel(e);
        acc = v && m_ready && !r;
        e++;
        m_acc = acc;
        if (r) begin
            seq = 0; m_old = 2'b00; m_new = 2'b00; done_edge = -100; m_ready = 1;
        end else begin
            if (acc) begin
                if (rs == cur) done_edge = e;
                else begin seq = 1; ta = e; m_old = cur; m_new = rs; end
            end
            m_ready = !f_busy(e) && !ov && !f_done(e);
        end
    endtask

    task automatic check_model();
        chk("s1s0",       {s1, s0},   f_sel(e));
        chk("ck_gate_en", ck_gate_en, f_gate(e));
        chk("busy",       busy,       f_busy(e));
        chk("done",       done,       f_done(e));
        chk("req_ready",  req_ready,  m_ready);
    endtask

    // Observation counters maintained on every cycle.
    int n_falls   = 0;
    int n_done    = 0;
    bit prev_gate = 1;

    task automatic cycle(input bit use_model);
        model_edge(rst, req_valid, req_sel, tst_override);
        @(posedge clk);
        #1;
        if (use_model) check_model();
        if (prev_gate === 1'b1 && ck_gate_en === 1'b0) n_falls++;
        prev_gate = ck_gate_en;
        if (done === 1'b1) n_done++;
    endtask

    task automatic issue(input logic [1:0] sel, output int t);
        t = -1;
        req_valid = 1'b1;
        req_sel   = sel;
        for (int i = 0; i < 60 && t < 0; i++) begin
            cycle(1);
            if (m_acc) t = e;
        end
        req_valid = 1'b0;
        chk("accept_timeout", (t >= 0), 1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1);
    endtask

    typedef struct {
        logic       rst, valid;
        logic [1:0] sel;
        logic       ovr;
        logic [1:0] x_sel;
        logic       x_gate, x_busy, x_done, x_ready;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int t, t2, f0, d0, low, doff;
        bit seen;
        logic [1:0] hold_sel;
        bit pend;

        rst = 1'b1; req_valid = 1'b0; req_sel = 2'b00; tst_override = 1'b0;
        rst2 = 1'b1; req_valid2 = 1'b0; req_sel2 = 2'b00; tst_override2 = 1'b0;

        //            rst   valid sel    ovr    x_sel  gate  busy  done  ready
        tbl[0] = '{1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset, first post-reset cycle, same-select at 00, override in IDLE.
        for (int i = 0; i < 9; i++) begin
            rst = tbl[i].rst; req_valid = tbl[i].valid;
            req_sel = tbl[i].sel; tst_override = tbl[i].ovr;
            cycle(0);
            chk($sformatf("tbl%0d_sel", i),   {s1, s0},   tbl[i].x_sel);
            chk($sformatf("tbl%0d_gate", i),  ck_gate_en, tbl[i].x_gate);
            chk($sformatf("tbl%0d_busy", i),  busy,       tbl[i].x_busy);
            chk($sformatf("tbl%0d_done", i),  done,       tbl[i].x_done);
            chk($sformatf("tbl%0d_ready", i), req_ready,  tbl[i].x_ready);
        end
        req_valid = 1'b0; tst_override = 1'b0;

        // Switch 00 -> 10 with default timing.
        f0 = n_falls;
        issue(2'b10, t);
        low  = (ck_gate_en === 1'b0) ? 1 : 0;
        doff = -1;
        for (int i = 0; i < 20; i++) begin
            cycle(1);
            if (ck_gate_en === 1'b0) low++;
            if (done === 1'b1 && doff < 0) doff = e - t;
        end
        chk("sw_gate_low_cycles", low, G + S);
        chk("sw_done_offset", doff, G + S + 1);
        chk("sw_sel_final", {s1, s0}, 2'b10);
        chk("sw_one_window", n_falls - f0, 1);

        // Same-select request: done next cycle, no gating, never busy.
        f0 = n_falls;
        issue(2'b10, t);
        chk("same_done", done, 1'b1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1);
            if (busy !== 1'b0) seen = 1;
        end
        chk("same_busy_seen", seen, 0);
        chk("same_no_window", n_falls - f0, 0);

        // Back-to-back: valid held, 01 then 11.
        f0 = n_falls;
        issue(2'b01, t);
        issue(2'b11, t2);
        chk("b2b_after_done", ((t2 - t) >= G + S + 2), 1);
        run(20);
        chk("b2b_sel_final", {s1, s0}, 2'b11);
        chk("b2b_two_windows", n_falls - f0, 2);

        // Override in IDLE with a pending request: frozen for 20 cycles.
        f0 = n_falls; d0 = n_done;
        tst_override = 1'b1;
        cycle(1);
        req_valid = 1'b1; req_sel = 2'b00;
        run(20);
        chk("ovr_idle_sel", {s1, s0}, 2'b11);
        chk("ovr_idle_no_window", n_falls - f0, 0);
        chk("ovr_idle_no_done", n_done - d0, 0);
        req_valid = 1'b0; tst_override = 1'b0;
        run(2);

        // Override raised 3 cycles into a switch.
        d0 = n_done;
        issue(2'b01, t);
        run(2);
        tst_override = 1'b1;
        run(15);
        chk("ovr_busy_done", n_done - d0, 1);
        chk("ovr_busy_sel", {s1, s0}, 2'b01);
        chk("ovr_busy_ready_low", req_ready, 1'b0);
        tst_override = 1'b0;
        cycle(1);
        chk("ovr_release_ready", req_ready, 1'b1);

        // Reset 6 cycles into a switch (selects already changed).
        d0 = n_done;
        issue(2'b10, t);
        run(5);
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        chk("midrst_sel", {s1, s0}, 2'b00);
        chk("midrst_gate", ck_gate_en, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        run(20);
        chk("midrst_no_done", n_done - d0, 0);

        // Randomized traffic; requester holds valid/sel until accepted.
        pend = 0; hold_sel = 2'b00;
        for (int i = 0; i < 600; i++) begin
            if (!pend && $urandom_range(2) == 0) begin
                pend = 1; hold_sel = 2'($urandom_range(3));
            end
            req_valid = pend; req_sel = hold_sel;
            if ($urandom_range(24) == 0) tst_override = ~tst_override;
            rst = ($urandom_range(199) == 0);
            cycle(1);
            if (m_acc) pend = 0;
        end
        rst = 1'b0; req_valid = 1'b0; tst_override = 1'b0;
        run(20);

        // Minimum-timing build: gate low exactly 2 cycles.
        rst2 = 1'b0;
        @(posedge clk); #1;
        chk("min_ready", req_ready2, 1'b1);
        req_valid2 = 1'b1; req_sel2 = 2'b11;
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        low  = (ck_gate_en2 === 1'b0) ? 1 : 0;
        seen = (busy2 === 1'b1);
        doff = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (ck_gate_en2 === 1'b0) low++;
            if (done2 === 1'b1 && doff < 0) doff = i;
        end
        chk("min_gate_low", low, G2 + S2);
        chk("min_done_offset", doff, G2 + S2 + 1);
        chk("min_sel", {s1_2, s0_2}, 2'b11);
        chk("min_busy_at_accept", seen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_c3lib_ckmux4_sel_seq
